inst_fetch_ctrl: RTL and testbench

- Instruction-fetch controller directly downstream of the PC stage.
- Takes the current PC, runs a req/ack read on instruction memory, and holds the fetched word for the decoder.
- Returns the PC-advance strobe (steve), imm16 and nPC_sel to the PC stage.
- nPC_sel = beq taken (opcode match AND ALU zero); the PC stage performs PC+4 or PC+4+(imm16<<2).

---
 rtl/inst_fetch_ctrl.sv | 148 ++++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch controller: latches the PC, runs a req/ack imem read, holds the word for
// the decoder and returns steve/imm16/nPC_sel. Optional IFETCH_ALIGN_CHECK_EN faults on misaligned PC.
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h00400020,
  parameter logic [5:0]  BEQ_OPCODE = 6'h04,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        dec_ready,
  input  logic        alu_zero,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [15:0] imm16,
  output logic        nPC_sel,
  output logic        steve,
  output logic        fault
);

  typedef enum logic [2:0] {StIdle, StWait, StHold, StAdv, StFault} state_e;

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        steve_q, steve_d;
  logic        fault_q, fault_d;
  logic        br_q, br_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        br_now;

  assign br_now = (instr_q[31:26] == BEQ_OPCODE) & alu_zero;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    valid_d = valid_q;
    steve_d = steve_q;
    fault_d = fault_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
`ifdef IFETCH_ALIGN_CHECK_EN
        // Misaligned PC is still captured so the faulting address is visible.
        addr_d = pc;
        if (pc[1:0] != 2'b00) begin
          fault_d = 1'b1;
          state_d = StFault;
        end else begin
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = StWait;
        end
`else
        addr_d  = pc & 32'hFFFF_FFFC;
        req_d   = 1'b1;
        cnt_d   = '0;
        state_d = StWait;
`endif
      end
      StWait: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          req_d   = 1'b0;
          valid_d = 1'b1;
          state_d = StHold;
        end else if (cnt_q >= CntLast) begin
          fault_d = 1'b1;
          req_d   = 1'b0;
          state_d = StFault;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StHold: begin
        if (dec_ready) begin
          valid_d = 1'b0;
          steve_d = 1'b1;
          br_d    = br_now;
          state_d = StAdv;
        end
      end
      StAdv: begin
        steve_d = 1'b0;
        br_d    = 1'b0;
        state_d = StIdle;
      end
      StFault: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
        steve_d = 1'b0;
        fault_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      steve_q <= 1'b0;
      fault_q <= 1'b0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      steve_q <= steve_d;
      fault_q <= fault_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
    end
  end

  // Branch decision is live while holding, then frozen for the PC-advance cycle.
  always_comb begin
    nPC_sel = 1'b0;
    if (state_q == StHold) nPC_sel = br_now;
    else if (state_q == StAdv) nPC_sel = br_q;
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign imm16       = instr_q[15:0];
  assign steve       = steve_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: transaction-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_inst_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h00400020;
  localparam int          TIMEOUT  = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dec_ready;
  logic        alu_zero;
  logic [31:0] instr;
  logic        instr_valid;
  logic [15:0] imm16;
  logic        nPC_sel;
  logic        steve;
  logic        fault;

  int checks = 0;
  int failures = 0;

  // Memory responder controls
  int          mem_lat = 1;
  logic [31:0] mem_word = '0;
  logic        resp_ack = 1'b0;
  logic        ack_force = 1'b0;
  int          req_run = 0;

  assign imem_ack   = resp_ack | ack_force;
  assign imem_rdata = mem_word;

  always #5 clk = ~clk;

  inst_fetch_ctrl #(
    .RESET_PC  (RESET_PC),
    .BEQ_OPCODE(6'h04),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .dec_ready  (dec_ready),
    .alu_zero   (alu_zero),
    .instr      (instr),
    .instr_valid(instr_valid),
    .imm16      (imm16),
    .nPC_sel    (nPC_sel),
    .steve      (steve),
    .fault      (fault)
  );

  // Memory acks once the request has been up for mem_lat+1 cycles (mem_lat<0: never).
  initial forever begin
    @(posedge clk);
    #2;
    if (imem_req) req_run = req_run + 1;
    else req_run = 0;
    resp_ack = imem_req && (mem_lat >= 0) && (req_run >= mem_lat + 1);
  end

  // Reference model: 0 idle, 1 waiting on memory, 2 holding word, 3 advancing, 4 faulted.
  int          m_ph = 0;
  int          m_cnt = 0;
  logic [31:0] m_addr = RESET_PC;
  logic [31:0] m_instr = '0;
  logic        m_fault = 1'b0;
  logic        m_br = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_ph <= 0; m_cnt <= 0; m_addr <= RESET_PC; m_instr <= '0; m_fault <= 1'b0; m_br <= 1'b0;
    end else begin
      case (m_ph)
        0: begin
`ifdef IFETCH_ALIGN_CHECK_EN
          m_addr <= pc;
          if (pc[1:0] != 2'b00) begin
            m_fault <= 1'b1; m_ph <= 4;
          end else begin
            m_ph <= 1; m_cnt <= 0;
          end
`else
          m_addr <= {pc[31:2], 2'b00};
          m_ph <= 1; m_cnt <= 0;
`endif
        end
        1: begin
          if (imem_ack) begin
            m_instr <= imem_rdata; m_ph <= 2;
          end else if (m_cnt + 1 >= TIMEOUT) begin
            m_fault <= 1'b1; m_ph <= 4;
          end else begin
            m_cnt <= m_cnt + 1;
          end
        end
        2: if (dec_ready) begin
          m_br <= (m_instr[31:26] == 6'h04) && alu_zero;
          m_ph <= 3;
        end
        3: m_ph <= 0;
        default: m_ph <= 4;
      endcase
    end
  end

  logic cmp_en = 1'b0;
  logic [84:0] exp_vec, act_vec;
  logic        exp_br;

  always @(negedge clk) begin
    if (cmp_en) begin
      exp_br = (m_ph == 2) ? ((m_instr[31:26] == 6'h04) && alu_zero) : ((m_ph == 3) ? m_br : 1'b0);
      exp_vec = {(m_ph == 1), m_addr, m_instr, (m_ph == 2), m_instr[15:0], exp_br, (m_ph == 3),
                 m_fault};
      act_vec = {imem_req, imem_addr, instr, instr_valid, imm16, nPC_sel, steve, fault};
      checks++;
      if (act_vec !== exp_vec) begin
        failures++;
        $display("FAIL cycle_model t=%0t actual req=%b addr=%h instr=%h v=%b imm=%h br=%b st=%b f=%b required req=%b addr=%h instr=%h v=%b imm=%h br=%b st=%b f=%b",
                 $time, act_vec[84], act_vec[83:52], act_vec[51:20], act_vec[19], act_vec[18:3],
                 act_vec[2], act_vec[1], act_vec[0], exp_vec[84], exp_vec[83:52], exp_vec[51:20],
                 exp_vec[19], exp_vec[18:3], exp_vec[2], exp_vec[1], exp_vec[0]);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input string name, output logic prev_ack);
    logic last;
    logic found;
    last = 1'b0; prev_ack = 1'b0; found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (instr_valid) begin
        prev_ack = last; found = 1'b1;
      end else begin
        last = imem_ack;
      end
    end
    if (!found) begin
      checks++; failures++;
      $display("FAIL %s actual=no_instr_valid required=instr_valid_within_40", name);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic pa;
    int   cnt;
    logic seen;
    reset = 1'b1; pc = 32'h00400020; dec_ready = 1'b1; alu_zero = 1'b0;
    mem_lat = 1; mem_word = 32'h012A4020;
    step();
    cmp_en = 1'b1;
    step();
    @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_instr", instr, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_steve", {31'd0, steve}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_imm16", {16'd0, imm16}, 32'd0);
    chk("rst_npc", {31'd0, nPC_sel}, 32'd0);
    step();
    reset = 1'b0;

    // Basic fetch, ack one cycle after request
    wait_valid("s1_valid", pa);
    chk("s1_ack_then_valid", {31'd0, pa}, 32'd1);
    chk("s1_instr", instr, 32'h012A4020);
    chk("s1_imm16", {16'd0, imm16}, 32'h00004020);
    chk("s1_npc", {31'd0, nPC_sel}, 32'd0);
    chk("s1_addr", imem_addr, 32'h00400020);
    @(negedge clk);
    chk("s1_steve_on", {31'd0, steve}, 32'd1);
    chk("s1_valid_off", {31'd0, instr_valid}, 32'd0);
    @(negedge clk);
    chk("s1_steve_off", {31'd0, steve}, 32'd0);

    // Taken / not-taken beq
    mem_word = 32'h1109FFFE; alu_zero = 1'b1; dec_ready = 1'b0;
    wait_valid("s2_valid", pa);
    chk("s2_npc_taken", {31'd0, nPC_sel}, 32'd1);
    chk("s2_imm16", {16'd0, imm16}, 32'h0000FFFE);
    step(); alu_zero = 1'b0;
    @(negedge clk);
    chk("s2_npc_not_taken", {31'd0, nPC_sel}, 32'd0);
    step(); alu_zero = 1'b1; dec_ready = 1'b1;
    @(negedge clk);
    chk("s2_npc_hold", {31'd0, nPC_sel}, 32'd1);
    step(); alu_zero = 1'b0;
    @(negedge clk);
    chk("s2_adv_steve", {31'd0, steve}, 32'd1);
    chk("s2_adv_npc_held", {31'd0, nPC_sel}, 32'd1);

    // Decoder stall for 5 cycles
    mem_word = 32'h8C220004; dec_ready = 1'b0; alu_zero = 1'b1;
    wait_valid("s3_valid", pa);
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      chk("s3_valid_stable", {31'd0, instr_valid}, 32'd1);
      chk("s3_instr_stable", instr, 32'h8C220004);
      chk("s3_no_steve", {31'd0, steve}, 32'd0);
    end
    mem_lat = -1;
    step(); dec_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (steve) cnt++;
    end
    chk("s3_one_steve", cnt, 32'd1);

    // Timeout with no ack
    cnt = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (fault) seen = 1'b1;
      else if (imem_req) cnt++;
    end
    chk("s4_fault_set", {31'd0, seen}, 32'd1);
    chk("s4_wait_cycles", cnt, TIMEOUT);
    chk("s4_req_dropped", {31'd0, imem_req}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (imem_req || !fault) seen = 1'b1;
    end
    chk("s4_terminal", {31'd0, seen}, 32'd0);
    step(); reset = 1'b1;
    step();
    @(negedge clk);
    chk("s4_rst_fault", {31'd0, fault}, 32'd0);
    chk("s4_rst_addr", imem_addr, RESET_PC);

    // Reset mid-WAIT, then an ack that must be ignored
    mem_lat = 3; mem_word = 32'hDEADBEEF; pc = 32'h00400100;
    step(); reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (imem_req) seen = 1'b1;
    end
    chk("s5_req_up", {31'd0, seen}, 32'd1);
    step(); reset = 1'b1;
    step(); reset = 1'b0; ack_force = 1'b1;
    @(negedge clk);
    chk("s5_rst_req", {31'd0, imem_req}, 32'd0);
    chk("s5_rst_instr", instr, 32'd0);
    step(); ack_force = 1'b0;
    @(negedge clk);
    chk("s5_new_req", {31'd0, imem_req}, 32'd1);
    chk("s5_ack_ignored_valid", {31'd0, instr_valid}, 32'd0);
    chk("s5_ack_ignored_instr", instr, 32'd0);
    chk("s5_addr", imem_addr, 32'h00400100);

    // Zero-wait throughput: one fetch every 4 cycles
    mem_lat = 0; dec_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (steve) seen = 1'b1;
    end
    chk("s5_steve_seen", {31'd0, seen}, 32'd1);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (steve) cnt++;
    end
    chk("s5_throughput", cnt, 32'd4);

    // Misaligned PC
    step(); reset = 1'b1; pc = 32'h00400022;
    step();
    step(); reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
`ifdef IFETCH_ALIGN_CHECK_EN
    chk("s6_fault", {31'd0, fault}, 32'd1);
    chk("s6_no_req", {31'd0, imem_req}, 32'd0);
    chk("s6_addr_raw", imem_addr, 32'h00400022);
`else
    chk("s6_fault", {31'd0, fault}, 32'd0);
    chk("s6_req", {31'd0, imem_req}, 32'd1);
    chk("s6_addr_aligned", imem_addr, 32'h00400020);
`endif
    step(); step();
    @(negedge clk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
